// File: rtl/mem_scheduler_pkg.sv
// mem_scheduler_pkg: shared types and constants for the two-port memory scheduler.
//   mem_in_type / mem_out_type : request / response bus records
//   init_mem_in / init_mem_out : idle (reset) values of those records
//   sched_state_type           : scheduler FSM states (DRAIN only used with
//                                MEM_SCHEDULER_TIMEOUT_EN)
//   mem_sched_timeout          : TIMEOUT value applied at instantiation
package mem_scheduler_pkg;

   localparam int mem_sched_timeout = 1023;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } sched_state_type;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic        mem_error;
      logic [31:0] mem_rdata;
   } mem_out_type;

   localparam mem_in_type  init_mem_in  = '0;
   localparam mem_out_type init_mem_out = '0;

endpackage

// File: rtl/mem_req_buffer.sv
// mem_req_buffer: one-entry pending request register for one scheduler port.
//   clock, reset : clock, async active-high reset
//   load         : capture req (only asserted while empty)
//   clear        : drop the entry once it has been issued downstream
//   req          : incoming port request
//   entry, full  : held request and its occupancy flag
module mem_req_buffer
   import mem_scheduler_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       clear,
   input  mem_in_type req,
   output mem_in_type entry,
   output logic       full
);

   // load only happens while empty and clear only while full, so the two
   // never collide
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry <= init_mem_in;
         full  <= 1'b0;
      end else if (load) begin
         entry <= req;
         full  <= 1'b1;
      end else if (clear) begin
         full  <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: shares one memory bus between the CPU instruction and data
// ports. Each port's single-cycle request is latched in a one-entry buffer,
// buffers are granted round-robin, one transaction is outstanding at a time
// and the downstream response is routed back to its owner combinationally.
//   clock, reset        : clock, async active-high reset
//   imem_in / imem_out  : instruction-port request / response
//   dmem_in / dmem_out  : data-port request / response
//   mem_in / mem_out    : shared downstream request (registered) / response
//   grant               : one-hot owner, bit0 = imem, bit1 = dmem, 0 when idle
//   busy                : transaction outstanding
// Optional: MEM_SCHEDULER_TIMEOUT_EN adds a wait counter that answers the
// owner with an error after TIMEOUT silent cycles, then drains the bus.
module mem_scheduler
   import mem_scheduler_pkg::*;
#(
   parameter int TIMEOUT    = mem_sched_timeout,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  mem_in,
   input  mem_out_type mem_out,
   output logic [1:0]  grant,
   output logic        busy
);

   sched_state_type state;
   logic            last_d;   // 1: dmem was issued last
   mem_in_type      i_entry, d_entry, next_req;
   logic            i_full, d_full;
   logic            any_full, pick_d, issue, tmo_hit, rsp_vld;
   mem_out_type     rsp;

   mem_req_buffer u_ibuf (
      .clock (clock),
      .reset (reset),
      .load  (imem_in.mem_valid && !i_full),
      .clear (issue && !pick_d),
      .req   (imem_in),
      .entry (i_entry),
      .full  (i_full)
   );

   mem_req_buffer u_dbuf (
      .clock (clock),
      .reset (reset),
      .load  (dmem_in.mem_valid && !d_full),
      .clear (issue && pick_d),
      .req   (dmem_in),
      .entry (d_entry),
      .full  (d_full)
   );

`ifdef MEM_SCHEDULER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] wait_cnt;

   // a real ready in the deadline cycle wins over the synthetic error
   assign tmo_hit = (state == BUSY) && !mem_out.mem_ready && (wait_cnt == TMO_MAX);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      any_full = i_full || d_full;
      // with both waiting, the port that did not go last wins
      pick_d   = d_full && (!i_full || !last_d);
      next_req = pick_d ? d_entry : i_entry;
      next_req.mem_valid = 1'b1;
      // back-to-back issue happens on the response edge of the previous one
      issue    = any_full && ((state == IDLE) || ((state == BUSY) && mem_out.mem_ready));
   end

   always_comb begin
      imem_out = init_mem_out;
      dmem_out = init_mem_out;
      rsp      = mem_out;
      rsp_vld  = (state == BUSY) && mem_out.mem_ready;
      if (tmo_hit) begin
         rsp     = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: '0};
         rsp_vld = 1'b1;
      end
      if (rsp_vld && grant[0]) imem_out = rsp;
      if (rsp_vld && grant[1]) dmem_out = rsp;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mem_in   <= init_mem_in;
         grant    <= 2'b00;
         busy     <= 1'b0;
         last_d   <= !DATA_FIRST;
`ifdef MEM_SCHEDULER_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         mem_in.mem_valid <= 1'b0;   // single-cycle strobe; other fields hold
         if (issue) begin
            mem_in   <= next_req;
            grant    <= pick_d ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            last_d   <= pick_d;
            state    <= BUSY;
`ifdef MEM_SCHEDULER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
         end else begin
            case (state)
               BUSY: begin
                  if (mem_out.mem_ready) begin
                     state <= IDLE;
                     grant <= 2'b00;
                     busy  <= 1'b0;
                  end
`ifdef MEM_SCHEDULER_TIMEOUT_EN
                  else if (tmo_hit) begin
                     // owner already answered; bus stays reserved while draining
                     state    <= DRAIN;
                     grant    <= 2'b00;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
`endif
               end
`ifdef MEM_SCHEDULER_TIMEOUT_EN
               DRAIN: begin
                  if (mem_out.mem_ready || (wait_cnt == TMO_LAST)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + CNT_W'(1);
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
